// File: rtl/cam_capture_ctrl.sv
// Frame capture sequencer: aligns to frame start and writes visible pixels to linear addresses.
// Define CAM_CAPTURE_SKID_EN to add a one-entry skid buffer behind the write port.
module cam_capture_ctrl #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 258,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  vid_pixel,
    input  logic              vid_pixsync,
    input  logic              vid_visible,
    input  logic              vid_vsync,
    input  logic              vid_locked,
    input  logic              cmd_start,
    input  logic              cmd_continuous,
    input  logic              cmd_stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              stat_busy,
    output logic              stat_done,
    output logic              stat_overflow,
    output logic              stat_frame_err,
    output logic [15:0]       stat_frames
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t              state_q, state_d;
    logic                cont_q, vsync_seen_q;
    logic [ADDR_W-1:0]   idx_q, cur_idx;
    logic                pix_in, take_pix, frame_err, wr_accept, port_busy, pend_empty, arm_cmd;
`ifdef CAM_CAPTURE_SKID_EN
    logic                skid_v_q;
    logic [ADDR_W-1:0]   skid_addr_q;
    logic [PIX_W-1:0]    skid_data_q;
`endif

    assign stat_busy = (state_q != S_IDLE);
    assign stat_done = (state_q == S_DONE);

    always_comb begin
        pix_in    = vid_pixsync && vid_visible;
        wr_accept = mem_we && mem_ready;
        port_busy = mem_we && !mem_ready;
        arm_cmd   = (state_q == S_IDLE) && cmd_start && !cmd_stop;
`ifdef CAM_CAPTURE_SKID_EN
        pend_empty = !mem_we && !skid_v_q;
`else
        pend_empty = !mem_we;
`endif
        // Short frame can only occur in CAPTURE: the last pixel moves us to DRAIN.
        frame_err = ((state_q == S_CAPTURE) && (!vid_locked || vid_vsync)) ||
                    ((state_q == S_DRAIN) && !vid_locked);
        take_pix  = 1'b0;
        cur_idx   = idx_q;
        state_d   = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm_cmd) state_d = S_ARM;
            end
            S_ARM: begin
                cur_idx = '0;
                if (cmd_stop || !vid_locked) begin
                    state_d = S_IDLE;
                end else if (vsync_seen_q && pix_in) begin
                    take_pix = 1'b1;
                    state_d  = (LAST_IDX == '0) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (frame_err) begin
                    state_d = S_IDLE;
                end else if (pix_in) begin
                    take_pix = 1'b1;
                    if (idx_q == LAST_IDX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_err)       state_d = S_IDLE;
                else if (pend_empty) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = (cont_q && !cmd_stop) ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q         <= 1'b0;
            vsync_seen_q   <= 1'b0;
            idx_q          <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            stat_overflow  <= 1'b0;
            stat_frame_err <= 1'b0;
            stat_frames    <= '0;
`ifdef CAM_CAPTURE_SKID_EN
            skid_v_q       <= 1'b0;
            skid_addr_q    <= '0;
            skid_data_q    <= '0;
`endif
        end else begin
            if (arm_cmd) begin
                cont_q         <= cmd_continuous;
                stat_overflow  <= 1'b0;
                stat_frame_err <= 1'b0;
            end else if (cmd_stop && (state_q != S_IDLE)) begin
                cont_q <= 1'b0;
            end

            if (state_q != S_ARM && state_d == S_ARM) vsync_seen_q <= 1'b0;
            else if (state_q == S_ARM && vid_vsync)   vsync_seen_q <= 1'b1;

            // Index advances for dropped pixels too, keeping frame geometry intact.
            if (take_pix) idx_q <= cur_idx + 1'b1;

            if (frame_err)         stat_frame_err <= 1'b1;
            if (state_q == S_DONE) stat_frames    <= stat_frames + 16'd1;

`ifdef CAM_CAPTURE_SKID_EN
            if (frame_err) begin
                mem_we   <= 1'b0;
                skid_v_q <= 1'b0;
            end else if (!port_busy) begin
                if (skid_v_q) begin
                    mem_we   <= 1'b1;
                    mem_addr <= skid_addr_q;
                    mem_data <= skid_data_q;
                    skid_v_q <= take_pix;
                    if (take_pix) begin
                        skid_addr_q <= cur_idx;
                        skid_data_q <= vid_pixel;
                    end
                end else if (take_pix) begin
                    mem_we   <= 1'b1;
                    mem_addr <= cur_idx;
                    mem_data <= vid_pixel;
                end else if (wr_accept) begin
                    mem_we <= 1'b0;
                end
            end else if (take_pix) begin
                if (!skid_v_q) begin
                    skid_v_q    <= 1'b1;
                    skid_addr_q <= cur_idx;
                    skid_data_q <= vid_pixel;
                end else begin
                    stat_overflow <= 1'b1;
                end
            end
`else
            if (frame_err) begin
                mem_we <= 1'b0;
            end else if (take_pix && !port_busy) begin
                mem_we   <= 1'b1;
                mem_addr <= cur_idx;
                mem_data <= vid_pixel;
            end else if (wr_accept) begin
                mem_we <= 1'b0;
            end
            if (take_pix && port_busy) stat_overflow <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl on a 4x2 frame; a write scoreboard checks every accepted write.
module tb_cam_capture_ctrl;

    localparam int unsigned W = 4, H = 2, AW = 8, PW = 12;
`ifdef CAM_CAPTURE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [PW-1:0] vid_pixel = '0;
    logic          vid_pixsync = 1'b0, vid_visible = 1'b0, vid_vsync = 1'b0, vid_locked = 1'b1;
    logic          cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_stop = 1'b0, mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data;
    logic          mem_we, stat_busy, stat_done, stat_overflow, stat_frame_err;
    logic [15:0]   stat_frames;

    cam_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync),
        .vid_visible(vid_visible), .vid_vsync(vid_vsync), .vid_locked(vid_locked),
        .cmd_start(cmd_start), .cmd_continuous(cmd_continuous), .cmd_stop(cmd_stop),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .stat_busy(stat_busy), .stat_done(stat_done), .stat_overflow(stat_overflow),
        .stat_frame_err(stat_frame_err), .stat_frames(stat_frames)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [PW-1:0] data; } wr_t;
    typedef struct { logic start, stop, cont, vsync, pix, locked, exp_busy, exp_we; } vec_t;

    wr_t sb[$];
    int  n_tests = 0, n_fail = 0, done_cnt = 0, pix_idx = 0;

    // Scoreboard: every accepted write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stat_done) done_cnt++;
            if (mem_we && mem_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        n_fail++;
                        $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                                 mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic cont);
        cmd_start = 1'b1; cmd_continuous = cont;
        step();
        cmd_start = 1'b0; cmd_continuous = 1'b0;
        pix_idx = 0;
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        repeat (4) step();
        vid_vsync = 1'b0;
        step();
    endtask

    task automatic pixel(input bit expect_wr);
        logic [PW-1:0] d;
        d = PW'($urandom) | PW'(1);
        vid_pixel = d; vid_pixsync = 1'b1; vid_visible = 1'b1;
        if (expect_wr) sb.push_back('{addr: AW'(pix_idx), data: d});
        pix_idx++;
        step();
        vid_pixsync = 1'b0; vid_visible = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && stat_busy; i++) step();
        check(name, 32'(stat_busy), 0);
    endtask

    vec_t vecs[10];
    int   d0, f0;

    initial begin
        // Idle/arm command handling, one cycle per record.
        vecs[0] = '{1,1,0,0,0,1, 0,0};  // start+stop together: stay idle
        vecs[1] = '{0,0,0,0,0,1, 0,0};
        vecs[2] = '{1,0,0,0,0,1, 1,0};  // arm
        vecs[3] = '{0,1,0,0,0,1, 0,0};  // stop cancels arm
        vecs[4] = '{1,0,1,0,0,1, 1,0};
        vecs[5] = '{0,0,0,0,0,0, 0,0};  // lock lost in arm
        vecs[6] = '{1,0,0,0,0,1, 1,0};
        vecs[7] = '{0,0,0,0,1,1, 1,0};  // pixel before any vsync: ignored
        vecs[8] = '{0,0,0,1,0,1, 1,0};
        vecs[9] = '{0,1,0,0,0,1, 0,0};

        repeat (3) step();
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_status", {stat_busy, stat_done, stat_overflow, stat_frame_err}, 0);
        check("rst_frames", 32'(stat_frames), 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            cmd_start = vecs[i].start; cmd_stop = vecs[i].stop; cmd_continuous = vecs[i].cont;
            vid_vsync = vecs[i].vsync; vid_pixsync = vecs[i].pix; vid_visible = vecs[i].pix;
            vid_locked = vecs[i].locked;
            step();
            check($sformatf("vec%0d_busy", i), 32'(stat_busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
        end
        cmd_start = 0; cmd_stop = 0; cmd_continuous = 0; vid_vsync = 0;
        vid_pixsync = 0; vid_visible = 0; vid_locked = 1;
        step();

        // Single-shot frame
        d0 = done_cnt;
        start_cmd(1'b0);
        vsync_pulse();
        repeat (W*H) pixel(1'b1);
        wait_idle("t1_idle");
        check("t1_done", 32'(done_cnt - d0), 1);
        check("t1_frames", 32'(stat_frames), 1);
        check("t1_flags", {stat_overflow, stat_frame_err}, 0);

        // Continuous, stop during third frame
        d0 = done_cnt;
        start_cmd(1'b1);
        for (int f = 0; f < 3; f++) begin
            pix_idx = 0;
            vsync_pulse();
            for (int p = 0; p < int'(W*H); p++) begin
                if (f == 2 && p == 3) begin
                    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
                end
                pixel(1'b1);
            end
        end
        wait_idle("t2_idle");
        check("t2_done", 32'(done_cnt - d0), 3);
        check("t2_frames", 32'(stat_frames), 4);
        check("t2_err", 32'(stat_frame_err), 0);

        // Backpressure across two strobes
        d0 = done_cnt;
        start_cmd(1'b0);
        vsync_pulse();
        mem_ready = 1'b0;
        pixel(1'b1);
        pixel(SKID);
        mem_ready = 1'b1;
        repeat (W*H-2) pixel(1'b1);
        wait_idle("t3_idle");
        check("t3_overflow", 32'(stat_overflow), SKID ? 0 : 1);
        check("t3_done", 32'(done_cnt - d0), 1);

        // Lock lost at pixel 5 with pixel 4 still pending
        d0 = done_cnt; f0 = stat_frames;
        start_cmd(1'b0);
        check("t4_ovf_clr", 32'(stat_overflow), 0);
        vsync_pulse();
        repeat (4) pixel(1'b1);
        mem_ready = 1'b0;
        pixel(1'b0);
        vid_locked = 1'b0; vid_pixsync = 1'b1; vid_visible = 1'b1;
        step();
        vid_pixsync = 1'b0; vid_visible = 1'b0;
        check("t4_we", 32'(mem_we), 0);
        check("t4_err", 32'(stat_frame_err), 1);
        check("t4_busy", 32'(stat_busy), 0);
        vid_locked = 1'b1; mem_ready = 1'b1;
        repeat (3) step();
        check("t4_done", 32'(done_cnt - d0), 0);
        check("t4_frames", 32'(stat_frames), 32'(f0));

        // Short frame with an overflow, then restart clears both flags
        start_cmd(1'b0);
        check("t5_err_clr", 32'(stat_frame_err), 0);
        vsync_pulse();
        mem_ready = 1'b0;
        pixel(1'b1);
        pixel(SKID);
        pixel(1'b0);
        mem_ready = 1'b1;
        repeat (3) pixel(1'b1);
        vid_vsync = 1'b1;
        step();
        vid_vsync = 1'b0;
        check("t5_err", 32'(stat_frame_err), 1);
        check("t5_ovf", 32'(stat_overflow), 1);
        check("t5_busy", 32'(stat_busy), 0);
        start_cmd(1'b0);
        check("t5_flags_clr", {stat_overflow, stat_frame_err}, 0);
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
        check("t5_cancel", 32'(stat_busy), 0);

        // Asynchronous reset mid-capture
        start_cmd(1'b0);
        vsync_pulse();
        mem_ready = 1'b0;
        pixel(1'b0);
        pixel(1'b0);
        check("t6_pending", 32'(mem_we), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", 32'(mem_we), 0);
        check("t6_rst_addr_data", {mem_addr, mem_data}, 0);
        check("t6_rst_status", {stat_busy, stat_overflow, stat_frame_err}, 0);
        check("t6_rst_frames", 32'(stat_frames), 0);
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
